ram_sync_dp: RTL and testbench
==============================

Name: ram_sync_dp

Overview:
- Parametrised synchronous dual-port RAM. It succeeds the asynchronous _OE/_WE RAM used for the CPU data and scratch memory.
- Port A is read/write. Port B is read-only and serves the display/debug tap.
- All accesses are registered on clk with 1-cycle read latency and a selectable write mode.
- A built-in clear sequencer fills memory with INIT_VALUE after every reset and replaces simulation-only initial loops.

Parameters:
- DWIDTH, 8: data width in bits.
- AWIDTH, 12: address width in bits.
- WORDS, 4096: implemented depth; must be <= 2**AWIDTH.
- WRITE_MODE, 0: port A read-during-write behaviour. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- INIT_VALUE, 0: DWIDTH-wide value written to every word by the clear sequencer.

Ports:
- clk, input, 1: sole clock; all state changes on posedge.
- reset, input, 1: synchronous, active-high reset.
- _ce_a, input, 1: port A enable, active low.
- _we_a, input, 1: port A write strobe, active low; qualified by _ce_a low.
- addr_a, input, AWIDTH: port A address.
- din_a, input, DWIDTH: port A write data.
- dout_a, output, DWIDTH: port A registered read data.
- _ce_b, input, 1: port B read enable, active low.
- addr_b, input, AWIDTH: port B address.
- dout_b, output, DWIDTH: port B registered read data.
- busy, output, 1: high while the clear sequence runs; user accesses are ignored.

Behaviour:
- Reset, sampled at posedge with reset=1:
  - dout_a <= 0, dout_b <= 0, busy <= 1.
  - Clear pointer <= 0; state <= CLEAR.
  - Memory contents are not otherwise touched that cycle.
  - Reset asserted at any time, including mid-clear, restarts the clear from address 0.
- State CLEAR, entered when reset is low:
  - Each posedge writes mem[ptr] <= INIT_VALUE, then ptr <= ptr+1.
  - On the posedge that writes ptr == WORDS-1: state <= READY, busy <= 0.
  - busy is therefore high for exactly WORDS posedges after reset deasserts, plus the reset cycles.
  - All port A/B requests are ignored during CLEAR; dout_a and dout_b stay 0.
- State READY, port A, when _ce_a=0:
  - _we_a=0: mem[addr_a] <= din_a. dout_a depends on WRITE_MODE:
    - READ_FIRST: dout_a <= old mem[addr_a].
    - WRITE_FIRST: dout_a <= din_a.
    - NO_CHANGE: dout_a holds.
  - _we_a=1: dout_a <= mem[addr_a].
- State READY, port A, when _ce_a=1: no access; dout_a holds.
- State READY, port B:
  - _ce_b=0: dout_b <= mem[addr_b].
  - _ce_b=1: dout_b holds.
- Cross-port collision (A writes address X while B reads X in the same cycle):
  - dout_b returns the old data, regardless of WRITE_MODE.
  - The new data is visible to B on the following access.
- Out-of-range address (addr >= WORDS, only possible when WORDS < 2**AWIDTH):
  - Write is discarded; memory is unchanged.
  - A read registers 0 on that port.
- Latency: data is valid on dout_x after the posedge that samples the request; 1 cycle.
- No combinational path from any input to dout_a, dout_b or busy.
- State encoding: CLEAR and READY only. No other states; an illegal encoding recovers to CLEAR.

Optional Feature:
- Macro: RAM_SYNC_DP_COLLISION_FLAG_EN.
- Defined:
  - Adds output port collision, 1 bit, registered, reset value 0.
  - collision goes high for exactly one cycle after any READY posedge where _ce_a=0, _we_a=0, _ce_b=0 and addr_a == addr_b (in range).
  - Otherwise collision is 0.
- Undefined: the port and all its logic are absent; all other behaviour is identical.

Test Plan:
- Clear sequence: WORDS=16, INIT_VALUE=8'hA5, reset held 2 cycles then low.
  - Required: busy is high through reset and 16 further posedges, then 0.
  - Reading port B at addresses 0..15 returns 8'hA5 each time, 1 cycle after each request.
- Reset mid-clear: assert reset for 1 cycle when ptr=7.
  - Required: busy stays 1, ptr restarts at 0, busy falls 16 posedges after reset low.
  - A port A write at addr 3 issued during busy is lost; addr 3 reads 8'hA5.
- Write modes: mem[5]=8'h11, then write 8'h22 to addr 5 on port A.
  - Required dout_a: READ_FIRST = 8'h11, WRITE_FIRST = 8'h22, NO_CHANGE = previous dout_a.
  - Subsequent read of addr 5 returns 8'h22 in all modes.
- Collision: mem[9]=8'h33; same cycle, A writes 8'h44 to addr 9 and B reads addr 9.
  - Required: dout_b = 8'h33 and collision = 1 for one cycle (if the macro is defined).
  - Next B read of addr 9 returns 8'h44 with collision = 0.
- Enables and range: WORDS=12, AWIDTH=4. Write 8'hFF to addr 13, then read addr 13.
  - Required: dout = 0 and no memory word is changed.
  - With _ce_a=1 and _ce_b=1 for 3 cycles, dout_a and dout_b hold their previous values.

Source files
------------

// File: rtl/ram_sync_dp.sv
`default_nettype none
// ============================================================================
// Module  : ram_sync_dp
// Brief   : Synchronous dual-port RAM (A: read/write, B: read-only) with a
//           post-reset clear sequencer. RAM_SYNC_DP_COLLISION_FLAG_EN adds a
//           registered cross-port collision flag.
// Rev     : 1.0 - initial release
// ============================================================================
module ram_sync_dp #(
  parameter int                DWIDTH     = 8,
  parameter int                AWIDTH     = 12,
  parameter int                WORDS      = 4096,
  parameter int                WRITE_MODE = 0,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              _ce_a,
  input  logic              _we_a,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [DWIDTH-1:0] din_a,
  output logic [DWIDTH-1:0] dout_a,
  input  logic              _ce_b,
  input  logic [AWIDTH-1:0] addr_b,
  output logic [DWIDTH-1:0] dout_b,
`ifdef RAM_SYNC_DP_COLLISION_FLAG_EN
  output logic              collision,
`endif
  output logic              busy
);

  localparam int                c_iw        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AWIDTH-1:0] c_last_ptr  = AWIDTH'(WORDS - 1);
  localparam logic [AWIDTH:0]   c_words_ext = (AWIDTH + 1)'(WORDS);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [AWIDTH-1:0]   r_ptr;
  logic [DWIDTH-1:0]   r_mem [0:WORDS-1];

  logic                w_ready;
  logic                w_clear_wr;
  logic                w_a_in_range;
  logic                w_b_in_range;
  logic                w_a_wr_ok;
  logic [c_iw-1:0]     w_a_idx;
  logic [c_iw-1:0]     w_b_idx;
  logic [c_iw-1:0]     w_ptr_idx;
  logic [DWIDTH-1:0]   w_a_rdata;
  logic [DWIDTH-1:0]   w_b_rdata;

  assign w_ready      = (r_state == ST_READY) && !reset;
  assign w_clear_wr   = (r_state == ST_CLEAR) && !reset;
  assign w_a_in_range = ({1'b0, addr_a} < c_words_ext);
  assign w_b_in_range = ({1'b0, addr_b} < c_words_ext);
  assign w_a_idx      = addr_a[c_iw-1:0];
  assign w_b_idx      = addr_b[c_iw-1:0];
  assign w_ptr_idx    = r_ptr[c_iw-1:0];
  assign w_a_wr_ok    = w_ready && !_ce_a && !_we_a && w_a_in_range;

  // Out-of-range addresses read as zero rather than aliasing onto real words.
  always_comb begin
    w_a_rdata = '0;
    w_b_rdata = '0;
    if (w_a_in_range) w_a_rdata = r_mem[w_a_idx];
    if (w_b_in_range) w_b_rdata = r_mem[w_b_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_CLEAR;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = ST_CLEAR;
    case (r_state)
      ST_CLEAR: w_state_next = (r_ptr == c_last_ptr) ? ST_READY : ST_CLEAR;
      ST_READY: w_state_next = ST_READY;
      default:  w_state_next = ST_CLEAR;
    endcase
  end

  assign busy = (r_state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset)                      r_ptr <= '0;
    else if (r_state == ST_CLEAR)   r_ptr <= r_ptr + AWIDTH'(1);
  end

  // Memory array carries no reset; the clear sequencer owns initialisation.
  always_ff @(posedge clk) begin
    if (w_clear_wr)     r_mem[w_ptr_idx] <= INIT_VALUE;
    else if (w_a_wr_ok) r_mem[w_a_idx]   <= din_a;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_a <= '0;
    end else if (w_ready && !_ce_a) begin
      if (_we_a) begin
        dout_a <= w_a_rdata;
      end else if (WRITE_MODE == 0) begin
        dout_a <= w_a_rdata;
      end else if (WRITE_MODE == 1) begin
        dout_a <= w_a_in_range ? din_a : '0;
      end
    end
  end

  // Nonblocking read of the array gives B the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (reset)                   dout_b <= '0;
    else if (w_ready && !_ce_b)  dout_b <= w_b_rdata;
  end

`ifdef RAM_SYNC_DP_COLLISION_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) collision <= 1'b0;
    else       collision <= w_a_wr_ok && !_ce_b && (addr_a == addr_b);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_sync_dp.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_sync_dp
// Brief   : Scoreboard bench for ram_sync_dp; three instances cover the
//           READ_FIRST / WRITE_FIRST / NO_CHANGE write modes.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_ram_sync_dp;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_a = 1'b1;
  logic       we_a = 1'b1;
  logic       ce_b = 1'b1;
  logic [3:0] addr_a = '0;
  logic [3:0] addr_b = '0;
  logic [7:0] din_a = '0;

  logic [7:0] dout_a [N];
  logic [7:0] dout_b [N];
  logic       busy   [N];
`ifdef RAM_SYNC_DP_COLLISION_FLAG_EN
  logic       coll   [N];
`endif

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    ram_sync_dp #(
      .DWIDTH    (8),
      .AWIDTH    (4),
      .WORDS     ((gi == 0) ? 16 : 12),
      .WRITE_MODE(gi),
      .INIT_VALUE(8'hA5)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      ._ce_a    (ce_a),
      ._we_a    (we_a),
      .addr_a   (addr_a),
      .din_a    (din_a),
      .dout_a   (dout_a[gi]),
      ._ce_b    (ce_b),
      .addr_b   (addr_b),
      .dout_b   (dout_b[gi]),
`ifdef RAM_SYNC_DP_COLLISION_FLAG_EN
      .collision(coll[gi]),
`endif
      .busy     (busy[gi])
    );
  end

  // Reference model: plain arrays plus a count of clear cycles still owed.
  int         m_mem  [N][16];
  int         m_left [N];
  logic [7:0] m_da   [N];
  logic [7:0] m_db   [N];
  logic       m_col  [N];

  typedef struct packed {
    logic [N-1:0]      bsy;
    logic [N-1:0][7:0] da;
    logic [N-1:0][7:0] db;
    logic [N-1:0]      col;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int words(input int i);
    return (i == 0) ? 16 : 12;
  endfunction

  task automatic model_step();
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      int w;
      bit a_in;
      bit b_in;
      int old_a;
      int old_b;
      w     = words(i);
      a_in  = int'(addr_a) < w;
      b_in  = int'(addr_b) < w;
      old_a = a_in ? m_mem[i][addr_a] : 0;
      old_b = b_in ? m_mem[i][addr_b] : 0;
      m_col[i] = 1'b0;
      if (reset) begin
        m_da[i]   = 8'h00;
        m_db[i]   = 8'h00;
        m_left[i] = w;
      end else if (m_left[i] > 0) begin
        m_mem[i][w - m_left[i]] = 8'hA5;
        m_left[i]--;
      end else begin
        if (!ce_a) begin
          if (we_a) begin
            m_da[i] = 8'(old_a);
          end else begin
            if (a_in) m_mem[i][addr_a] = int'(din_a);
            if (i == 0)      m_da[i] = 8'(old_a);
            else if (i == 1) m_da[i] = a_in ? din_a : 8'h00;
          end
        end
        if (!ce_b) m_db[i] = 8'(old_b);
        m_col[i] = !ce_a && !we_a && !ce_b && (addr_a == addr_b) && a_in;
      end
      e.bsy[i] = reset || (m_left[i] > 0);
      e.da[i]  = m_da[i];
      e.db[i]  = m_db[i];
      e.col[i] = m_col[i];
    end
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock; compared away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin : m_pop
        exp_t e;
        e = sb.pop_front();
        for (int i = 0; i < N; i++) begin
          check("busy", i, {7'b0, busy[i]}, {7'b0, e.bsy[i]});
          check("dout_a", i, dout_a[i], e.da[i]);
          check("dout_b", i, dout_b[i], e.db[i]);
`ifdef RAM_SYNC_DP_COLLISION_FLAG_EN
          check("collision", i, {7'b0, coll[i]}, {7'b0, e.col[i]});
`endif
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic cea, input logic wea, input logic [3:0] aa,
                     input logic [7:0] da, input logic ceb, input logic [3:0] ab);
    reset  = r;
    ce_a   = cea;
    we_a   = wea;
    addr_a = aa;
    din_a  = da;
    ce_b   = ceb;
    addr_b = ab;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    cyc(1, 1, 1, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 0, 1, 0);
    for (int k = 0; k < 7; k++) cyc(0, 1, 1, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 0, 1, 0);
    // Accesses during the restarted clear must be ignored.
    for (int k = 0; k < 16; k++) cyc(0, 1'(k != 4), 0, 3, 8'h77, 0, 4'(k));
    for (int k = 0; k < 16; k++) cyc(0, 1, 1, 0, 0, 0, 4'(k));
    cyc(0, 0, 1, 3, 0, 1, 0);
    // Read-during-write modes.
    cyc(0, 0, 0, 5, 8'h11, 1, 0);
    cyc(0, 0, 0, 5, 8'h22, 1, 0);
    cyc(0, 0, 1, 5, 0, 1, 0);
    // Cross-port collision.
    cyc(0, 0, 0, 9, 8'h33, 1, 0);
    cyc(0, 0, 0, 9, 8'h44, 0, 9);
    cyc(0, 1, 1, 0, 0, 0, 9);
    // Out-of-range write/read, then idle holds.
    cyc(0, 0, 0, 13, 8'hFF, 1, 0);
    cyc(0, 0, 1, 13, 0, 0, 13);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 4'(k), 8'h5A, 1, 4'(k));
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, 4'(15 - k), 0, 0, 4'(k));
    // Randomised traffic with rare resets.
    for (int k = 0; k < 500; k++) begin
      cyc(1'($urandom_range(0, 249) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
          1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    #1;
    check("sb_empty", 0, 8'(sb.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
